// File: rtl/cu_uop_seq_pkg.sv
// cu_uop_seq_pkg: shared sizes, FSM state encoding and the latched job descriptor layout.
//   PE_NUM  - PEs in the compute unit (width of every PE mask)
//   DATA_W  - width of pe_num, num_mac and the writeback channel offset
//   FRAM_AW - feature RAM address width
//   KRAM_AW - kernel RAM address width
package cu_uop_seq_pkg;
    localparam int PE_NUM  = 32;
    localparam int DATA_W  = 16;
    localparam int FRAM_AW = 12;
    localparam int KRAM_AW = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_MAC, S_BIAS, S_OUT, S_FLUSH, S_WAIT_WB, S_WAIT_DONE
    } uop_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  num_mac;
        logic [DATA_W-1:0]  pe_num;
        logic               bias;
        logic               relu;
        logic               last;
        logic [FRAM_AW-1:0] feat_base;
        logic [KRAM_AW-1:0] kern_base;
        logic [FRAM_AW-1:0] wb_base;
        logic [DATA_W-1:0]  wb_chofs;
    } cu_cmd_t;
endpackage

// File: rtl/cu_uop_seq_if.sv
// cu_uop_seq_if: job descriptor channel into the micro-op sequencer.
//   valid - descriptor valid (master -> slave)
//   ready - sequencer can take a descriptor (slave -> master)
//   cmd   - descriptor fields, sampled on valid && ready
interface cu_uop_seq_if;
    import cu_uop_seq_pkg::*;
    logic    valid;
    logic    ready;
    cu_cmd_t cmd;
    modport master (output valid, cmd, input ready);
    modport slave  (input valid, cmd, output ready);
endinterface

// File: rtl/cu_uop_seq_pe_mask.sv
// cu_uop_seq_pe_mask: pe_num -> thermometer mask of active PEs plus an out-of-range flag.
//   pe_num_i  - requested active PE count
//   mask_o    - (1 << pe_num) - 1, saturating to all ones
//   illegal_o - pe_num is 0 or larger than PE_NUM
module cu_uop_seq_pe_mask
    import cu_uop_seq_pkg::*;
(
    input  logic [DATA_W-1:0] pe_num_i,
    output logic [PE_NUM-1:0] mask_o,
    output logic              illegal_o
);
    assign mask_o    = ~({PE_NUM{1'b1}} << pe_num_i);
    assign illegal_o = pe_num_i == '0 || pe_num_i > DATA_W'(PE_NUM);
endmodule

// File: rtl/cu_uop_seq.sv
// cu_uop_seq: micro-op sequencer driving the compute unit for one convolution job at a time.
//   clk, rst              - clock, asynchronous active-high reset
//   cmd_if                - job descriptor valid/ready channel (slave side)
//   feat/kern_raddr_o     - BRAM read addresses, rd_en_o - BRAM read enable
//   in_valid/calc_bias/calc_relu/out_en_o, flush_o, bias_sel_o - cu controls, one cycle behind the reads
//   valid_pe_num/last_uop/wb_baseaddr/wb_ch_offset_o - descriptor fields forwarded to cu
//   wb_busy_i, illegal_uop_i, compute_done_i - cu status
//   job_done_o, job_err_o - one-cycle completion / error pulses
module cu_uop_seq
    import cu_uop_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cu_uop_seq_if.slave        cmd_if,
    output logic [FRAM_AW-1:0] feat_raddr_o,
    output logic [KRAM_AW-1:0] kern_raddr_o,
    output logic               rd_en_o,
    output logic               bias_sel_o,
    output logic [DATA_W-1:0]  valid_pe_num_o,
    output logic [PE_NUM-1:0]  in_valid_o,
    output logic [PE_NUM-1:0]  calc_bias_o,
    output logic [PE_NUM-1:0]  calc_relu_o,
    output logic [PE_NUM-1:0]  out_en_o,
    output logic               flush_o,
    output logic               last_uop_o,
    output logic [FRAM_AW-1:0] wb_baseaddr_o,
    output logic [DATA_W-1:0]  wb_ch_offset_o,
    input  logic               wb_busy_i,
    input  logic               illegal_uop_i,
    input  logic               compute_done_i,
    output logic               job_done_o,
    output logic               job_err_o
);
    uop_state_e        state_q, state_d;
    cu_cmd_t           cmd_q;
    logic [PE_NUM-1:0] mask_q, mask_w;
    logic [DATA_W-1:0] k_q, k_d;
    logic iv_q, iv_d, bsel_q, bsel_d, out_q, out_d, flush_q, flush_d;
    logic done_q, done_d, err_q, err_d;
    logic accept, bad_pe, bad_cmd, abort;

    cu_uop_seq_pe_mask u_mask (
        .pe_num_i  (cmd_if.cmd.pe_num),
        .mask_o    (mask_w),
        .illegal_o (bad_pe)
    );

    assign cmd_if.ready = !rst && state_q == S_IDLE;
    assign accept       = cmd_if.valid && cmd_if.ready;
    assign bad_cmd      = bad_pe || cmd_if.cmd.num_mac == '0;
    assign abort        = state_q != S_IDLE && illegal_uop_i;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                k_d     = '0;
                err_d   = accept && bad_cmd;
                state_d = accept && !bad_cmd ? S_MAC : S_IDLE;
            end
            S_MAC: begin
                // k runs one past the last MAC so the bias read lands on kern_base+N
                k_d     = k_q + 1'b1;
                state_d = k_q != cmd_q.num_mac - 1'b1 ? S_MAC : cmd_q.bias ? S_BIAS : S_OUT;
            end
            S_BIAS:  state_d = S_OUT;
            S_OUT:   state_d = S_FLUSH;
            S_FLUSH: state_d = S_WAIT_WB;
            S_WAIT_WB: begin
                // the flush itself is still on the wire during the first WAIT_WB cycle
                if (!wb_busy_i && !flush_q) begin
                    done_d  = !cmd_q.last;
                    state_d = cmd_q.last ? S_WAIT_DONE : S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                done_d  = compute_done_i;
                state_d = compute_done_i ? S_IDLE : S_WAIT_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
        // control stage follows the read stage by one cycle to match BRAM latency
        iv_d    = !abort && (state_q == S_MAC || state_q == S_BIAS);
        bsel_d  = !abort && state_q == S_BIAS;
        out_d   = !abort && state_q == S_OUT;
        flush_d = !abort && state_q == S_FLUSH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            mask_q  <= '0;
            k_q     <= '0;
            iv_q    <= 1'b0;
            bsel_q  <= 1'b0;
            out_q   <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            iv_q    <= iv_d;
            bsel_q  <= bsel_d;
            out_q   <= out_d;
            flush_q <= flush_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                cmd_q  <= cmd_if.cmd;
                mask_q <= mask_w;
            end
        end
    end

    assign rd_en_o        = state_q == S_MAC || state_q == S_BIAS;
    assign feat_raddr_o   = rd_en_o ? cmd_q.feat_base + k_q[FRAM_AW-1:0] : '0;
    assign kern_raddr_o   = rd_en_o ? cmd_q.kern_base + k_q[KRAM_AW-1:0] : '0;
    assign in_valid_o     = iv_q ? mask_q : '0;
    assign calc_bias_o    = bsel_q ? mask_q : '0;
    assign bias_sel_o     = bsel_q;
    assign out_en_o       = out_q ? mask_q : '0;
    assign calc_relu_o    = out_q && cmd_q.relu ? mask_q : '0;
    assign flush_o        = flush_q;
    assign job_done_o     = done_q;
    assign job_err_o      = err_q;
    assign valid_pe_num_o = cmd_q.pe_num;
    assign last_uop_o     = cmd_q.last;
    assign wb_baseaddr_o  = cmd_q.wb_base;
    assign wb_ch_offset_o = cmd_q.wb_chofs;
endmodule

// File: tb/tb_cu_uop_seq.sv
// tb_cu_uop_seq: cycle-accurate vector table plus hand-written busy/abort/reset sequences for cu_uop_seq.
module tb_cu_uop_seq;
    import cu_uop_seq_pkg::*;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] M27 = 32'h07FF_FFFF;

    typedef struct packed {
        logic        ready, rd;
        logic [11:0] f;
        logic [9:0]  k;
        logic [31:0] iv, cb, cr, oe;
        logic        bs, fl, dn, er;
    } outs_t;

    typedef struct {
        logic    v;
        cu_cmd_t c;
        logic    busy, ill, cd;
        outs_t   exp;
    } vec_t;

    logic clk = 1'b0, rst;
    logic [11:0] feat, wb_base;
    logic [9:0]  kern;
    logic rd_en, bsel, flush, last_uop, wb_busy, ill, cdone, done, err;
    logic [15:0] vpe, chofs;
    logic [31:0] iv, cb, cr, oe;
    outs_t act;
    vec_t  vq[$];
    int    total = 0, bad = 0;

    cu_uop_seq_if ifc ();

    cu_uop_seq dut (
        .clk(clk), .rst(rst), .cmd_if(ifc),
        .feat_raddr_o(feat), .kern_raddr_o(kern), .rd_en_o(rd_en), .bias_sel_o(bsel),
        .valid_pe_num_o(vpe), .in_valid_o(iv), .calc_bias_o(cb), .calc_relu_o(cr), .out_en_o(oe),
        .flush_o(flush), .last_uop_o(last_uop), .wb_baseaddr_o(wb_base), .wb_ch_offset_o(chofs),
        .wb_busy_i(wb_busy), .illegal_uop_i(ill), .compute_done_i(cdone),
        .job_done_o(done), .job_err_o(err)
    );

    always #5 clk = ~clk;

    assign act = {ifc.ready, rd_en, feat, kern, iv, cb, cr, oe, bsel, flush, done, err};

    function automatic cu_cmd_t mk(int n, int pe, logic b, logic r, logic l,
                                   logic [11:0] fb, logic [9:0] kb, logic [11:0] wb, logic [15:0] ch);
        cu_cmd_t c;
        c.num_mac = 16'(n); c.pe_num = 16'(pe); c.bias = b; c.relu = r; c.last = l;
        c.feat_base = fb; c.kern_base = kb; c.wb_base = wb; c.wb_chofs = ch;
        return c;
    endfunction

    task automatic add(logic v, cu_cmd_t c, logic busy, logic il, logic cd,
                       logic rdy, logic rd, logic [11:0] f, logic [9:0] k,
                       logic [31:0] i, logic [31:0] b, logic [31:0] r, logic [31:0] o,
                       logic bs, logic fl, logic dn, logic er);
        vec_t x;
        x.v = v; x.c = c; x.busy = busy; x.ill = il; x.cd = cd;
        x.exp = {rdy, rd, f, k, i, b, r, o, bs, fl, dn, er};
        vq.push_back(x);
    endtask

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // each vector is one clock cycle: inputs driven after the edge, outputs sampled on the falling edge
    task automatic run_vecs(string tag);
        foreach (vq[i]) begin
            ifc.valid = vq[i].v; ifc.cmd = vq[i].c;
            wb_busy = vq[i].busy; ill = vq[i].ill; cdone = vq[i].cd;
            @(negedge clk);
            total++;
            if (act !== vq[i].exp) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", tag, i, act, vq[i].exp);
            end
            tick();
        end
        vq.delete();
        ifc.valid = 1'b0; wb_busy = 1'b0; ill = 1'b0; cdone = 1'b0;
    endtask

    // N=10, pe=27, relu, last: in_valid cycles 2..11, out 12, flush 13, done after compute_done
    task automatic gen_s1();
        cu_cmd_t c = mk(10, 27, 0, 1, 1, 12'h000, 10'h000, 12'h123, 16'd100);
        add(1, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 10; j++)
            add(0, c, 0, 0, 0, 0, 1, 12'(j - 1), 10'(j - 1), j >= 2 ? M27 : 32'h0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, M27, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, M27, M27, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        cu_cmd_t c;
        int n;
        logic any;
        rst = 1'b1; ifc.valid = 1'b0; ifc.cmd = '0; wb_busy = 1'b0; ill = 1'b0; cdone = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        add(0, '0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // N=3, pe=32, bias: kern 5..8, bias on 4th in_valid, out_en right after
        c = mk(3, 32, 1, 0, 0, 12'h010, 10'd5, 12'h200, 16'd7);
        add(1, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'h010, 10'd5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'h011, 10'd6, ALL, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'h012, 10'd7, ALL, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'h013, 10'd8, ALL, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, ALL, ALL, 0, 0, 1, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // rejects back to back: pe=0, pe=33, N=0
        add(1, mk(4, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, mk(4, 33, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, mk(0, 4, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, '0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, '0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        gen_s1();
        run_vecs("tbl");

        // wb_busy high for 5 cycles after flush, last=0
        ifc.valid = 1'b1; ifc.cmd = mk(2, 4, 0, 0, 0, 0, 0, 0, 0); wb_busy = 1'b1;
        tick();
        ifc.valid = 1'b0;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (flush) break;
            tick();
            n++;
        end
        chk("s4_flush_seen", 64'(flush), 64'd1);
        tick();
        any = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            any = any | done | ifc.ready;
            tick();
        end
        chk("s4_hold_while_busy", 64'(any), 64'd0);
        wb_busy = 1'b0;
        @(negedge clk);
        chk("s4_no_early_done", 64'(done), 64'd0);
        tick();
        @(negedge clk);
        chk("s4_done_ready", {62'd0, done, ifc.ready}, 64'd3);
        tick();
        @(negedge clk);
        chk("s4_done_pulse", 64'(done), 64'd0);
        tick();

        // illegal_uop on the 4th MAC cycle
        ifc.valid = 1'b1; ifc.cmd = mk(10, 8, 0, 0, 0, 0, 0, 0, 0);
        tick();
        ifc.valid = 1'b0;
        repeat (3) tick();
        ill = 1'b1;
        @(negedge clk);
        chk("s5_iv_before_abort", {32'd0, iv}, 64'h0000_0000_0000_00FF);
        tick();
        ill = 1'b0;
        @(negedge clk);
        chk("s5_abort", {iv, 29'd0, rd_en, err, ifc.ready}, 64'd3);
        tick();
        @(negedge clk);
        chk("s5_err_pulse", 64'(err), 64'd0);
        tick();

        // reset mid-MAC
        ifc.valid = 1'b1; ifc.cmd = mk(10, 27, 0, 1, 1, 0, 0, 12'h123, 16'd100);
        tick();
        ifc.valid = 1'b0;
        tick();
        @(negedge clk);
        chk("s6_fwd", {19'd0, vpe, wb_base, chofs, last_uop}, {19'd0, 16'd27, 12'h123, 16'd100, 1'b1});
        chk("s6_iv_running", {32'd0, iv}, {32'd0, M27});
        tick();
        rst = 1'b1;
        #1;
        chk("s6_async_clear", {iv, vpe, feat, rd_en, ifc.ready, last_uop, err, done},
            64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s6_after_rst", {60'd0, ifc.ready, done, err, rd_en}, 64'd8);
        tick();
        gen_s1();
        // feature and kernel addresses wrap
        c = mk(3, 27, 0, 1, 0, 12'hFFE, 10'h3FE, 0, 0);
        add(1, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'hFFE, 10'h3FE, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'hFFF, 10'h3FF, M27, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 1, 12'h000, 10'h000, M27, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, M27, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, M27, M27, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, c, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vecs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
